pwm_gen: RTL and testbench

//   Free-running, single-channel PWM generator with programmable period and duty cycle.

---
 rtl/pwm_gen.sv | 67 ++++++
 tb/tb_pwm_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen.sv
// Single-channel free-running PWM: counter 0..period-1, registered compare against duty.
// Optional PWM_SHADOW_EN: duty/period latched at period wrap (and first clk after reset).
module pwm_gen #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty_cycle,
    input  logic [WIDTH-1:0] period,
    output logic             pwm_out,
    output logic             period_end
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty_eff;
    logic [WIDTH-1:0] period_eff;
    logic             period_zero;
    logic             wrap;

`ifdef PWM_SHADOW_EN
    logic [WIDTH-1:0] duty_q;
    logic [WIDTH-1:0] period_q;
    logic             first_q;
    logic             load;

    // On the first clk after reset the live inputs are used directly so the
    // first period is not lost to an all-zero shadow.
    assign duty_eff   = first_q ? duty_cycle : duty_q;
    assign period_eff = first_q ? period     : period_q;
    // A zero period never wraps, so keep reloading until a real period arrives.
    assign load       = first_q || wrap || period_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q   <= '0;
            period_q <= '0;
            first_q  <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (load) begin
                duty_q   <= duty_cycle;
                period_q <= period;
            end
        end
    end
`else
    assign duty_eff   = duty_cycle;
    assign period_eff = period;
`endif

    assign period_zero = (period_eff == '0);
    // ">=" rather than "==" so a period shrunk below cnt wraps immediately.
    assign wrap        = !period_zero && (cnt >= period_eff - WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            pwm_out    <= 1'b0;
            period_end <= 1'b0;
        end else begin
            cnt        <= (period_zero || wrap) ? '0 : cnt + WIDTH'(1);
            pwm_out    <= !period_zero && ((duty_eff >= period_eff) || (cnt < duty_eff));
            period_end <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen (default build, live duty/period): table, corner sequences, random vs model.
module tb_pwm_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] duty_cycle;
    logic [W-1:0] period;
    logic         pwm_out;
    logic         period_end;

    int vectors = 0;
    int errors  = 0;

    pwm_gen #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .duty_cycle (duty_cycle),
        .period     (period),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;
        int duty;
        int cycles;
        int exp_high;
        int exp_end;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse reset for one clock; inputs set by the caller stay applied.
    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic run_count(input int n, output int highs, output int ends);
        highs = 0;
        ends  = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            highs += int'(pwm_out);
            ends  += int'(period_end);
        end
    endtask

    // Reference: position within the current PWM period, advanced per clk.
    int m_pos;
    int exp_pwm;
    int exp_end;

    task automatic model_step(input bit r, input int p, input int d);
        if (r || p == 0) begin
            m_pos   = 0;
            exp_pwm = 0;
            exp_end = 0;
        end else begin
            exp_end = (m_pos >= p - 1) ? 1 : 0;
            exp_pwm = (d >= p) ? 1 : ((m_pos < d) ? 1 : 0);
            m_pos   = (exp_end == 1) ? 0 : m_pos + 1;
        end
    endtask

    initial begin
        int h;
        int e;
        rst        = 1'b1;
        duty_cycle = '0;
        period     = '0;

        tbl[0]  = '{100,  25, 300,  75,  3};
        tbl[1]  = '{100,   0, 300,   0,  3};
        tbl[2]  = '{100, 100, 300, 300,  3};
        tbl[3]  = '{100, 150, 300, 300,  3};
        tbl[4]  = '{  0,  10,  50,   0,  0};
        tbl[5]  = '{  1,   0,  20,   0, 20};
        tbl[6]  = '{  1,   1,  20,  20, 20};
        tbl[7]  = '{  1,   5,  20,  20, 20};
        tbl[8]  = '{255, 254, 510, 508,  2};
        tbl[9]  = '{255, 255, 510, 510,  2};
        tbl[10] = '{  7,   3,  21,   9,  3};
        tbl[11] = '{  2,   1,  10,   5,  5};

        repeat (2) @(posedge clk);
        #1;
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_end", int'(period_end), 0);

        for (int i = 0; i < 12; i++) begin
            period     = W'(tbl[i].per);
            duty_cycle = W'(tbl[i].duty);
            do_reset();
            run_count(tbl[i].cycles, h, e);
            check($sformatf("tbl%0d_high", i), h, tbl[i].exp_high);
            check($sformatf("tbl%0d_end", i), e, tbl[i].exp_end);
        end

        // Duty lowered mid high phase: output follows on the next compare.
        period = 8'd100; duty_cycle = 8'd50;
        do_reset();
        repeat (30) @(posedge clk);
        #1;
        check("duty_chg_before", int'(pwm_out), 1);
        duty_cycle = 8'd10;
        @(posedge clk); #1;
        check("duty_chg_next", int'(pwm_out), 0);
        repeat (69) @(posedge clk);
        run_count(100, h, e);
        check("duty_chg_period_high", h, 10);
        check("duty_chg_period_end", e, 1);

        // Period shrunk below the running count: immediate wrap, then 40-clk periods.
        period = 8'd100; duty_cycle = 8'd20;
        do_reset();
        repeat (80) @(posedge clk);
        #1;
        period = 8'd40;
        @(posedge clk); #1;
        check("shrink_wrap_end", int'(period_end), 1);
        run_count(39, h, e);
        check("shrink_gap_end", e, 0);
        @(posedge clk); #1;
        check("shrink_next_end", int'(period_end), 1);
        h += int'(pwm_out);
        check("shrink_high", h, 20);

        // Asynchronous reset during the high phase.
        period = 8'd100; duty_cycle = 8'd50;
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        check("arst_pre_pwm", int'(pwm_out), 1);
        #3 rst = 1'b1;
        #1;
        check("arst_pwm", int'(pwm_out), 0);
        check("arst_end", int'(period_end), 0);
        @(posedge clk); #1 rst = 1'b0;
        run_count(100, h, e);
        check("arst_after_high", h, 50);
        check("arst_after_end", e, 1);

        // Randomized inputs and occasional resets against the reference model.
        period     = W'($urandom_range(0, 20));
        duty_cycle = W'($urandom_range(0, 25));
        do_reset();
        m_pos = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            model_step(rst, int'(period), int'(duty_cycle));
            #1;
            check("rand_pwm", int'(pwm_out), exp_pwm);
            check("rand_end", int'(period_end), exp_end);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #1;
                check("rand_arst", int'({pwm_out, period_end}), 0);
            end
            if ($urandom_range(0, 15) == 0) period = W'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0) duty_cycle = W'($urandom_range(0, 25));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
